host_wb_bridge: RTL and testbench

- Lets the external host CPU use the async SRAM-style bus (addr, sram_data, nwe, noe, ncs) to act as a Wishbone master.
- Connects to conbus master port m2, which the lm32 system leaves unused.
- Host accesses a small register window: it loads address, data and byte-select, then triggers a single 32-bit Wishbone read or write. It polls status for completion.
- Provides the host with the initiator end of the system bus; lm32 remains master0/master1.

---
 rtl/host_wb_bridge_if.sv | 25 ++
 rtl/host_wb_bridge.sv | 210 +++++++++++++++++++++
 tb/tb_host_wb_bridge.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/host_wb_bridge_if.sv
// rtl/host_wb_bridge_if.sv - Wishbone master-port bundle used by host_wb_bridge
// Signals:
//   m_adr_o/m_dat_o/m_sel_o/m_we_o/m_cyc_o/m_stb_o : driven by the bridge (master)
//   m_dat_i/m_ack_i                                : driven by the bus slave
// Modports: master (bridge side), slave (bus/slave side).
interface host_wb_bridge_if;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic [31:0] m_dat_i;
    logic [3:0]  m_sel_o;
    logic        m_we_o;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic        m_ack_i;

    modport master (
        output m_adr_o, m_dat_o, m_sel_o, m_we_o, m_cyc_o, m_stb_o,
        input  m_dat_i, m_ack_i
    );

    modport slave (
        input  m_adr_o, m_dat_o, m_sel_o, m_we_o, m_cyc_o, m_stb_o,
        output m_dat_i, m_ack_i
    );
endinterface

// File: rtl/host_wb_bridge.sv
// rtl/host_wb_bridge.sv - async SRAM-style host port acting as a single-beat Wishbone master
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   addr[12:0]        : host address, addr[3:0] selects a register, addr[12:4] must be 0
//   sram_data_i/_o/_oe: host data in, register read data out, pad drive enable
//   nwe, noe, ncs     : host strobes, active-low, asynchronous to clk
//   wb                : Wishbone master port (host_wb_bridge_if.master)
// Parameter wb_timeout: stb cycles allowed before the bus cycle is aborted.
// Optional macro HOST_WB_AUTOINC_EN: ADDR advances by 4 after each acked cycle.
module host_wb_bridge #(
    parameter int unsigned wb_timeout = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] addr,
    input  logic [7:0]  sram_data_i,
    output logic [7:0]  sram_data_o,
    output logic        sram_data_oe,
    input  logic        nwe,
    input  logic        noe,
    input  logic        ncs,
    host_wb_bridge_if.master wb
);
    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t      state_q, state_d;
    logic        cs_s1_q, cs_s1_d, cs_s_q, cs_s_d;
    logic        we_s1_q, we_s1_d, we_s_q, we_s_d, we_prev_q, we_prev_d;
    logic [3:0]  sh_reg_q, sh_reg_d;
    logic        sh_hit_q, sh_hit_d;
    logic [7:0]  sh_data_q, sh_data_d;
    logic [31:0] addr_reg_q, addr_reg_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        busy_q, busy_d, done_q, done_d, tmo_q, tmo_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [31:0] adr_o_q, adr_o_d, dat_o_q, dat_o_d;
    logic [3:0]  sel_o_q, sel_o_d;
    logic        we_o_q, we_o_d, cyc_q, cyc_d;
    logic        commit;

    // A commit is the synchronised rising edge of nwe while still selected;
    // it always uses the shadow copy of addr/data taken while nwe was low.
    assign commit = we_s_q & ~we_prev_q & ~cs_s_q & sh_hit_q;

    always_comb begin
        state_d    = state_q;
        cs_s1_d    = ncs;
        cs_s_d     = cs_s1_q;
        we_s1_d    = nwe;
        we_s_d     = we_s1_q;
        we_prev_d  = we_s_q;
        sh_reg_d   = sh_reg_q;
        sh_hit_d   = sh_hit_q;
        sh_data_d  = sh_data_q;
        addr_reg_d = addr_reg_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        sel_d      = sel_q;
        we_d       = we_q;
        busy_d     = busy_q;
        done_d     = done_q;
        tmo_d      = tmo_q;
        cnt_d      = cnt_q;
        adr_o_d    = adr_o_q;
        dat_o_d    = dat_o_q;
        sel_o_d    = sel_o_q;
        we_o_d     = we_o_q;
        cyc_d      = cyc_q;

        if (!we_s_q && !cs_s_q) begin
            sh_reg_d  = addr[3:0];
            sh_hit_d  = (addr[12:4] == 9'd0);
            sh_data_d = sram_data_i;
        end

        case (state_q)
            ST_IDLE: begin
                if (commit && sh_reg_q == 4'd8 && sh_data_q[0]) begin
                    state_d = ST_WAIT;
                    adr_o_d = {addr_reg_q[31:2], 2'b00};
                    dat_o_d = wdata_q;
                    sel_o_d = sh_data_q[7:4];
                    we_o_d  = sh_data_q[1];
                    cyc_d   = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    tmo_d   = 1'b0;
                    cnt_d   = 10'd0;
                end
            end
            ST_WAIT: begin
                // Ack is tested first so it wins over a same-cycle timeout.
                if (wb.m_ack_i) begin
                    state_d = ST_IDLE;
                    cyc_d   = 1'b0;
                    we_o_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (!we_o_q) begin
                        rdata_d = wb.m_dat_i;
                    end
`ifdef HOST_WB_AUTOINC_EN
                    addr_reg_d = addr_reg_q + 32'd4;
`endif
                end else if (cnt_q == 10'(wb_timeout - 1)) begin
                    state_d = ST_IDLE;
                    cyc_d   = 1'b0;
                    we_o_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Host register writes; the START bit only matters in the FSM above.
        if (commit) begin
            case (sh_reg_q)
                4'd0, 4'd1, 4'd2, 4'd3: addr_reg_d[{sh_reg_q[1:0], 3'b000} +: 8] = sh_data_q;
                4'd4, 4'd5, 4'd6, 4'd7: wdata_d[{sh_reg_q[1:0], 3'b000} +: 8] = sh_data_q;
                4'd8: begin
                    sel_d = sh_data_q[7:4];
                    we_d  = sh_data_q[1];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cs_s1_q    <= 1'b1;
            cs_s_q     <= 1'b1;
            we_s1_q    <= 1'b1;
            we_s_q     <= 1'b1;
            we_prev_q  <= 1'b1;
            sh_reg_q   <= 4'd0;
            sh_hit_q   <= 1'b0;
            sh_data_q  <= 8'd0;
            addr_reg_q <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            sel_q      <= 4'hF;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
            cnt_q      <= 10'd0;
            adr_o_q    <= 32'd0;
            dat_o_q    <= 32'd0;
            sel_o_q    <= 4'd0;
            we_o_q     <= 1'b0;
            cyc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cs_s1_q    <= cs_s1_d;
            cs_s_q     <= cs_s_d;
            we_s1_q    <= we_s1_d;
            we_s_q     <= we_s_d;
            we_prev_q  <= we_prev_d;
            sh_reg_q   <= sh_reg_d;
            sh_hit_q   <= sh_hit_d;
            sh_data_q  <= sh_data_d;
            addr_reg_q <= addr_reg_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tmo_q      <= tmo_d;
            cnt_q      <= cnt_d;
            adr_o_q    <= adr_o_d;
            dat_o_q    <= dat_o_d;
            sel_o_q    <= sel_o_d;
            we_o_q     <= we_o_d;
            cyc_q      <= cyc_d;
        end
    end

    // Host read path is deliberately unsynchronised: decoded from raw pins.
    always_comb begin
        sram_data_o = 8'h00;
        if (addr[12:4] == 9'd0) begin
            case (addr[3:0])
                4'd0, 4'd1, 4'd2, 4'd3: sram_data_o = addr_reg_q[{addr[1:0], 3'b000} +: 8];
                4'd4, 4'd5, 4'd6, 4'd7: sram_data_o = rdata_q[{addr[1:0], 3'b000} +: 8];
                4'd8:                   sram_data_o = {sel_q, 2'b00, we_q, 1'b0};
                4'd9:                   sram_data_o = {5'd0, tmo_q, done_q, busy_q};
                default:                sram_data_o = 8'h00;
            endcase
        end
    end

    assign sram_data_oe = ~ncs & ~noe & nwe;

    assign wb.m_adr_o = adr_o_q;
    assign wb.m_dat_o = dat_o_q;
    assign wb.m_sel_o = sel_o_q;
    assign wb.m_we_o  = we_o_q;
    assign wb.m_cyc_o = cyc_q;
    assign wb.m_stb_o = cyc_q;
endmodule

// File: tb/tb_host_wb_bridge.sv
// tb/tb_host_wb_bridge.sv - self-checking bench for host_wb_bridge
module tb_host_wb_bridge;
    logic        clk;
    logic        rst;
    logic [12:0] addr;
    logic [7:0]  sram_data_i;
    logic [7:0]  sram_data_o;
    logic        sram_data_oe;
    logic        nwe, noe, ncs;

    host_wb_bridge_if wb();

    host_wb_bridge #(.wb_timeout(1023)) dut (
        .clk(clk), .rst(rst), .addr(addr), .sram_data_i(sram_data_i),
        .sram_data_o(sram_data_o), .sram_data_oe(sram_data_oe),
        .nwe(nwe), .noe(noe), .ncs(ncs), .wb(wb.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave model state
    int          ack_lat = 0;         // 0 = never ack
    logic [31:0] slave_rdata = 32'h0;
    int          cyc_count = 0;
    int          cur_stb = 0;
    int          last_stb_cycles = 0;
    logic        prev_stb = 1'b0;
    logic [31:0] rec_adr, rec_dat;
    logic [3:0]  rec_sel;
    logic        rec_we;
    logic        last_oe;

    // Reference model of the host-visible registers
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_sel;
    logic        exp_we;

    initial begin
        wb.m_ack_i = 1'b0;
        wb.m_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            wb.m_ack_i = 1'b0;
            wb.m_dat_i = $urandom;
            if (wb.m_stb_o) begin
                if (!prev_stb) begin
                    cyc_count++;
                    rec_adr = wb.m_adr_o;
                    rec_dat = wb.m_dat_o;
                    rec_sel = wb.m_sel_o;
                    rec_we  = wb.m_we_o;
                    cur_stb = 0;
                end
                cur_stb++;
                last_stb_cycles = cur_stb;
                if (ack_lat > 0 && cur_stb == ack_lat) begin
                    wb.m_ack_i = 1'b1;
                    wb.m_dat_i = slave_rdata;
                end
            end
            prev_stb = wb.m_stb_o;
        end
    end

    task automatic host_write(input logic [12:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; sram_data_i = d; ncs = 1'b0; nwe = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        nwe = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        ncs = 1'b1;
        @(posedge clk);
    endtask

    task automatic host_read(input logic [12:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; ncs = 1'b0; noe = 1'b0;
        #2;
        d = sram_data_o;
        last_oe = sram_data_oe;
        noe = 1'b1; ncs = 1'b1;
    endtask

    task automatic write32(input logic [12:0] base, input logic [31:0] v);
        for (int i = 0; i < 4; i++) host_write(base + 13'(i), v[8*i +: 8]);
    endtask

    task automatic read32(input logic [12:0] base, output logic [31:0] v);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            host_read(base + 13'(i), b);
            v[8*i +: 8] = b;
        end
    endtask

    task automatic wait_done(input int max_cycles);
        logic [7:0] s;
        int n;
        s = 8'h01; n = 0;
        while (s[0] && n < max_cycles) begin
            host_read(13'd9, s);
            n++;
        end
        checks++;
        if (s[0]) begin
            errors++;
            $display("FAIL wait_done: still busy after %0d cycles, status=%02h", n, s);
        end
    endtask

    // Model of what an acked cycle does to the host-visible registers
    task automatic model_ack(input logic we);
        if (!we) exp_rdata = slave_rdata;
`ifdef HOST_WB_AUTOINC_EN
        exp_addr = exp_addr + 32'd4;
`endif
    endtask

    task automatic model_reset();
        exp_addr = 0; exp_wdata = 0; exp_rdata = 0; exp_sel = 4'hF; exp_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        logic [7:0] exp_bytes [10];
        exp_bytes = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h00};
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            host_read(13'(i), v);
            checks++;
            if (v !== exp_bytes[i]) begin
                errors++;
                $display("FAIL reset_reg%0d: got %02h want %02h", i, v, exp_bytes[i]);
            end
        end
        checks++;
        if (last_oe !== 1'b1) begin
            errors++;
            $display("FAIL read_oe: got %b want 1", last_oe);
        end
        host_read(13'h018, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("FAIL miss_read: got %02h want 00", v);
        end
        @(negedge clk);
        addr = 13'd9; ncs = 1'b0; noe = 1'b1;
        #2;
        checks++;
        if (sram_data_oe !== 1'b0 || wb.m_cyc_o !== 1'b0 || wb.m_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: oe=%b cyc=%b stb=%b want 0 0 0", sram_data_oe, wb.m_cyc_o, wb.m_stb_o);
        end
        ncs = 1'b1;
    endtask

    task automatic test_write_cycle();
        logic [7:0] s;
        int c0;
        write32(13'd0, 32'h2000_0004); exp_addr = 32'h2000_0004;
        write32(13'd4, 32'h0000_00A5); exp_wdata = 32'h0000_00A5;
        ack_lat = 3;
        c0 = cyc_count;
        host_write(13'd8, 8'hF3); exp_sel = 4'hF; exp_we = 1'b1;
        host_read(13'd9, s);
        checks++;
        if (s !== 8'h01) begin
            errors++;
            $display("FAIL wr_status_busy: got %02h want 01", s);
        end
        wait_done(50);
        model_ack(1'b1);
        host_read(13'd9, s);
        checks++;
        if (s !== 8'h02) begin
            errors++;
            $display("FAIL wr_status_done: got %02h want 02", s);
        end
        checks++;
        if (cyc_count !== c0 + 1 || rec_adr !== 32'h2000_0004 || rec_dat !== 32'h0000_00A5 ||
            rec_sel !== 4'hF || rec_we !== 1'b1) begin
            errors++;
            $display("FAIL wr_bus: n=%0d adr=%08h dat=%08h sel=%h we=%b want n=%0d 20000004 000000a5 f 1",
                     cyc_count - c0, rec_adr, rec_dat, rec_sel, rec_we, 1);
        end
        checks++;
        if (last_stb_cycles !== 3) begin
            errors++;
            $display("FAIL wr_stb_len: got %0d want 3", last_stb_cycles);
        end
    endtask

    task automatic test_read_cycle();
        logic [31:0] v;
        logic [7:0]  s;
        write32(13'd0, 32'h0000_0100); exp_addr = 32'h0000_0100;
        ack_lat = 1;
        slave_rdata = 32'hDEAD_BEEF;
        host_write(13'd8, 8'hF1); exp_sel = 4'hF; exp_we = 1'b0;
        wait_done(50);
        model_ack(1'b0);
        read32(13'd4, v);
        checks++;
        if (v !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rd_data: got %08h want deadbeef", v);
        end
        host_read(13'd9, s);
        checks++;
        if (s !== 8'h02 || rec_adr !== 32'h0000_0100 || rec_we !== 1'b0 || last_stb_cycles !== 1) begin
            errors++;
            $display("FAIL rd_status: st=%02h adr=%08h we=%b len=%0d want 02 00000100 0 1",
                     s, rec_adr, rec_we, last_stb_cycles);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] v;
        logic [7:0]  s;
        ack_lat = 0;
        slave_rdata = 32'h1234_5678;
        host_write(13'd8, 8'hF1);
        wait_done(1200);
        host_read(13'd9, s);
        checks++;
        if (s !== 8'h06 || last_stb_cycles !== 1023) begin
            errors++;
            $display("FAIL timeout: st=%02h stb_cycles=%0d want 06 1023", s, last_stb_cycles);
        end
        read32(13'd4, v);
        checks++;
        if (v !== exp_rdata) begin
            errors++;
            $display("FAIL timeout_rdata: got %08h want %08h", v, exp_rdata);
        end
        read32(13'd0, v);
        checks++;
        if (v !== exp_addr) begin
            errors++;
            $display("FAIL timeout_addr: got %08h want %08h", v, exp_addr);
        end
    endtask

    task automatic test_ack_timeout_same();
        logic [31:0] v;
        logic [7:0]  s;
        ack_lat = 1023;
        slave_rdata = $urandom;
        host_write(13'd8, 8'hF1);
        wait_done(1200);
        model_ack(1'b0);
        host_read(13'd9, s);
        checks++;
        if (s !== 8'h02 || last_stb_cycles !== 1023) begin
            errors++;
            $display("FAIL ack_vs_timeout: st=%02h stb_cycles=%0d want 02 1023", s, last_stb_cycles);
        end
        read32(13'd4, v);
        checks++;
        if (v !== exp_rdata) begin
            errors++;
            $display("FAIL ack_vs_timeout_rdata: got %08h want %08h", v, exp_rdata);
        end
    endtask

    task automatic test_start_while_busy();
        logic [7:0] s;
        int c0;
        logic [31:0] a0;
        ack_lat = 40;
        slave_rdata = $urandom;
        a0 = exp_addr;
        c0 = cyc_count;
        host_write(13'd8, 8'hF1);
        host_write(13'd8, 8'h03);
        exp_sel = 4'h0; exp_we = 1'b1;
        host_write(13'd0, 8'h40);
        exp_addr[7:0] = 8'h40;
        wait_done(100);
        model_ack(1'b0);
        repeat (60) @(posedge clk);
        checks++;
        if (cyc_count !== c0 + 1 || rec_adr !== {a0[31:2], 2'b00} || rec_we !== 1'b0 || rec_sel !== 4'hF) begin
            errors++;
            $display("FAIL busy_start: n=%0d adr=%08h we=%b sel=%h want 1 %08h 0 f",
                     cyc_count - c0, rec_adr, rec_we, rec_sel, {a0[31:2], 2'b00});
        end
        host_read(13'd8, s);
        checks++;
        if (s !== {exp_sel, 2'b00, exp_we, 1'b0}) begin
            errors++;
            $display("FAIL busy_ctrl: got %02h want %02h", s, {exp_sel, 2'b00, exp_we, 1'b0});
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d, v;
        logic [3:0]  sel;
        logic        we;
        logic [7:0]  s;
        int c0;
        for (int n = 0; n < 6; n++) begin
            a = $urandom; d = $urandom; sel = 4'($urandom); we = 1'($urandom);
            ack_lat = int'($urandom_range(1, 6));
            slave_rdata = $urandom;
            write32(13'd0, a); exp_addr = a;
            write32(13'd4, d); exp_wdata = d;
            c0 = cyc_count;
            host_write(13'd8, {sel, 2'b00, we, 1'b1}); exp_sel = sel; exp_we = we;
            wait_done(50);
            checks++;
            if (cyc_count !== c0 + 1 || rec_adr !== {a[31:2], 2'b00} || rec_sel !== sel || rec_we !== we ||
                (we && rec_dat !== exp_wdata) || last_stb_cycles !== ack_lat) begin
                errors++;
                $display("FAIL rand%0d_bus: n=%0d adr=%08h dat=%08h sel=%h we=%b len=%0d want adr=%08h dat=%08h sel=%h we=%b len=%0d",
                         n, cyc_count - c0, rec_adr, rec_dat, rec_sel, rec_we, last_stb_cycles,
                         {a[31:2], 2'b00}, exp_wdata, sel, we, ack_lat);
            end
            model_ack(we);
            read32(13'd4, v);
            host_read(13'd9, s);
            checks++;
            if (v !== exp_rdata || s !== 8'h02) begin
                errors++;
                $display("FAIL rand%0d_rdata: rdata=%08h st=%02h want %08h 02", n, v, s, exp_rdata);
            end
            read32(13'd0, v);
            checks++;
            if (v !== exp_addr) begin
                errors++;
                $display("FAIL rand%0d_addr: got %08h want %08h", n, v, exp_addr);
            end
        end
    endtask

`ifdef HOST_WB_AUTOINC_EN
    task automatic test_autoinc();
        logic [31:0] v, first_adr;
        write32(13'd0, 32'h0000_0100); exp_addr = 32'h0000_0100;
        ack_lat = 2;
        slave_rdata = $urandom;
        host_write(13'd8, 8'hF1); exp_sel = 4'hF; exp_we = 1'b0;
        wait_done(50);
        model_ack(1'b0);
        first_adr = rec_adr;
        host_write(13'd8, 8'hF1);
        wait_done(50);
        model_ack(1'b0);
        checks++;
        if (first_adr !== 32'h100 || rec_adr !== 32'h104) begin
            errors++;
            $display("FAIL autoinc_bus: got %08h %08h want 00000100 00000104", first_adr, rec_adr);
        end
        read32(13'd0, v);
        checks++;
        if (v !== 32'h108 || v !== exp_addr) begin
            errors++;
            $display("FAIL autoinc_addr: got %08h want 00000108", v);
        end
    endtask
`endif

    task automatic test_reset_mid_cycle();
        logic [7:0] s;
        ack_lat = 0;
        host_write(13'd8, 8'hF1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (wb.m_cyc_o !== 1'b0 || wb.m_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: cyc=%b stb=%b want 0 0", wb.m_cyc_o, wb.m_stb_o);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        host_read(13'd9, s);
        checks++;
        if (s !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_status: got %02h want 00", s);
        end
        host_read(13'd8, s);
        checks++;
        if (s !== {exp_sel, 2'b00, exp_we, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_ctrl: got %02h want %02h", s, {exp_sel, 2'b00, exp_we, 1'b0});
        end
    endtask

    initial begin
        rst = 1'b0; addr = 13'd0; sram_data_i = 8'd0;
        nwe = 1'b1; noe = 1'b1; ncs = 1'b1;
        last_oe = 1'b0;
        model_reset();
        test_reset();
        test_write_cycle();
        test_read_cycle();
        test_timeout();
        test_ack_timeout_same();
        test_start_while_busy();
        test_random();
`ifdef HOST_WB_AUTOINC_EN
        test_autoinc();
`endif
        test_reset_mid_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
